// File: rtl/pc_seq_pkg.sv
// Shared constants for the fetch-stage next-PC sequencer.
package pc_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] DEF_RESET_ADDR = 32'd0;
    localparam logic [31:0] DEF_HALT_ADDR  = 32'd248;
    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] ADDR_MASK      = 32'hFFFF_FFFC;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ADDR_MASK;
    endfunction

endpackage

// File: rtl/pc_flush_timer.sv
// Loadable down-counter; flush_o is high while the count is non-zero.
module pc_flush_timer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk_i,
    input  logic start_i,
    input  logic load_i,
    input  logic clr_i,
    output logic flush_o
);

    localparam logic [1:0] LOAD_VAL = 2'(FLUSH_CYCLES);

    logic [1:0] cnt_q;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            cnt_q <= 2'd0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
        end
    end

    assign flush_o = (cnt_q != 2'd0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: increment, hold, redirect or halt each cycle.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR   = DEF_RESET_ADDR,
    parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             hazard_i,
    input  logic             imem_ready_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    output logic [31:0]      pc_o,
    output logic             fetch_req_o,
    output logic             flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] stall_q;
    logic             redirect;
    logic             stall_inc;
    logic             halt_enter;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        redirect  = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                // Reaching the halt address beats any same-cycle redirect.
                if (pc_q == HALT_ADDR) begin
                    state_d = ST_HALT;
                end else if (jump_i) begin
                    pc_d     = word_align(jump_target_i);
                    redirect = 1'b1;
                end else if (branch_taken_i) begin
                    pc_d     = word_align(branch_target_i);
                    redirect = 1'b1;
                end else if (hazard_i || !imem_ready_i) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_d = pc_q + PC_INC;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign halt_enter = (state_d == ST_HALT);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_ADDR;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    pc_flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_timer (
        .clk_i  (clk_i),
        .start_i(start_i),
        .load_i (redirect),
        .clr_i  (halt_enter),
        .flush_o(flush_o)
    );

    assign pc_o        = pc_q;
    assign fetch_req_o = (state_q == ST_RUN);
    assign halted_o    = (state_q == ST_HALT);
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        start = 1'b1;
    logic        hazard = 1'b0;
    logic        ready = 1'b1;
    logic        br = 1'b0;
    logic        jmp = 1'b0;
    logic [31:0] br_t = 32'd0;
    logic [31:0] jmp_t = 32'd0;

    logic [31:0] pc, pc_s;
    logic        fetch, flush, halted, fetch_s, flush_s, halted_s;
    logic [15:0] stall;
    logic [2:0]  stall_s;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: mode 0 = just out of reset, 1 = fetching, 2 = finished.
    int          m_mode = 0;
    logic [31:0] m_pc = 32'd0;
    int          m_stalls = 0;
    int          m_flush = 0;

    pc_sequencer dut (
        .clk_i(clk), .start_i(start), .hazard_i(hazard), .imem_ready_i(ready),
        .branch_taken_i(br), .branch_target_i(br_t), .jump_i(jmp), .jump_target_i(jmp_t),
        .pc_o(pc), .fetch_req_o(fetch), .flush_o(flush), .halted_o(halted),
        .stall_cnt_o(stall)
    );

    pc_sequencer #(.CNT_W(3)) dut_s (
        .clk_i(clk), .start_i(start), .hazard_i(hazard), .imem_ready_i(ready),
        .branch_taken_i(br), .branch_target_i(br_t), .jump_i(jmp), .jump_target_i(jmp_t),
        .pc_o(pc_s), .fetch_req_o(fetch_s), .flush_o(flush_s), .halted_o(halted_s),
        .stall_cnt_o(stall_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? 32'(top) : 32'(n);
    endfunction

    always @(posedge clk or negedge start) begin
        if (!start) begin
            m_mode   <= 0;
            m_pc     <= 32'd0;
            m_stalls <= 0;
            m_flush  <= 0;
        end else if (m_mode == 0) begin
            m_mode <= 1;
        end else if (m_mode == 1) begin
            if (m_pc == 32'd248) begin
                m_mode  <= 2;
                m_flush <= 0;
            end else if (jmp) begin
                m_pc    <= {jmp_t[31:2], 2'b00};
                m_flush <= 2;
            end else if (br) begin
                m_pc    <= {br_t[31:2], 2'b00};
                m_flush <= 2;
            end else begin
                m_flush <= (m_flush > 0) ? m_flush - 1 : 0;
                if (hazard || !ready) m_stalls <= m_stalls + 1;
                else m_pc <= m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc", pc, m_pc);
            check("fetch_req", fetch, m_mode == 1);
            check("flush", flush, (m_flush != 0) && (m_mode != 2));
            check("halted", halted, m_mode == 2);
            check("stall_cnt", stall, sat(m_stalls, 16));
            check("pc_small", pc_s, m_pc);
            check("stall_cnt_small", stall_s, sat(m_stalls, 3));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_fetch"}, fetch, 32'd0);
        check({tag, "_flush"}, flush, 32'd0);
        check({tag, "_halted"}, halted, 32'd0);
        check({tag, "_stall"}, stall, 32'd0);
    endtask

    initial begin
        #2 start = 1'b0;
        #1 cmp_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        #1;
        check("idle_fetch", fetch, 32'd0);
        check("idle_pc", pc, 32'd0);

        // Sequential fetch from the reset address.
        tick(1); check("seq0", pc, 32'd0); check("seq0_fetch", fetch, 32'd1);
        tick(1); check("seq1", pc, 32'd4);
        tick(1); check("seq2", pc, 32'd8);
        tick(1); check("seq3", pc, 32'd12);
        tick(5); check("at_0x20", pc, 32'h20);

        hazard = 1'b1;
        tick(3); check("hazard_hold", pc, 32'h20); check("hazard_cnt", stall, 32'd3);
        hazard = 1'b0;
        tick(1); check("hazard_release", pc, 32'h24);
        ready = 1'b0;
        tick(2); check("imem_hold", pc, 32'h24); check("imem_cnt", stall, 32'd5);
        ready = 1'b1;

        // Redirects: jump, then a branch during flush with a hazard raised.
        jmp = 1'b1; jmp_t = 32'h10;
        tick(1); check("jump_0x10", pc, 32'h10); check("jump_flush", flush, 32'd1);
        jmp = 1'b0; br = 1'b1; br_t = 32'h83; hazard = 1'b1;
        tick(1); check("branch_align", pc, 32'h80); check("branch_nocount", stall, 32'd5);
        br = 1'b0; hazard = 1'b0;
        tick(1); check("flush_reload", flush, 32'd1); check("after_branch", pc, 32'h84);
        tick(1); check("flush_done", flush, 32'd0);

        jmp = 1'b1; jmp_t = 32'h100; br = 1'b1; br_t = 32'h200;
        tick(1); check("jump_priority", pc, 32'h100);
        br = 1'b0; jmp_t = 32'hFFFF_FFFC;
        tick(1); check("top_addr", pc, 32'hFFFF_FFFC);
        jmp = 1'b0;
        tick(1); check("wrap", pc, 32'd0);
        tick(1); check("wrap_next", pc, 32'd4);

        // Asynchronous reset mid-flush.
        jmp = 1'b1; jmp_t = 32'h40;
        tick(1); check("pre_reset_flush", flush, 32'd1);
        jmp = 1'b0;
        #2 start = 1'b0;
        #1 check_reset_values("rst_flush");
        @(negedge clk);
        start = 1'b1;

        // Asynchronous reset mid-stall; the 3-bit instance saturates.
        hazard = 1'b1;
        tick(11); check("long_stall", stall, 32'd10); check("sat_stall", stall_s, 32'd7);
        #2 start = 1'b0;
        #1 check_reset_values("rst_stall");
        @(negedge clk);
        start = 1'b1; hazard = 1'b0;

        // Run to the halt address, then try to escape with a jump.
        tick(63); check("reach_halt", pc, 32'd248); check("pre_halt", halted, 32'd0);
        jmp = 1'b1; jmp_t = 32'h40;
        tick(1); check("halted", halted, 32'd1); check("halt_fetch", fetch, 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick(1); check("halt_frozen", pc, 32'd248);
        end
        jmp = 1'b0;
        #2 start = 1'b0;
        #1 check_reset_values("rst_halt");
        @(negedge clk);
        start = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                #2 start = 1'b0;
                #2 start = 1'b1;
            end
            hazard = ($urandom_range(0, 9) < 3);
            ready  = ($urandom_range(0, 9) < 8);
            jmp    = ($urandom_range(0, 19) == 0);
            br     = ($urandom_range(0, 11) == 0);
            jmp_t  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            br_t   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
